// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : shared ALU control codes, M-extension funct3 and sequencer states
// Rev 1.0
// ============================================================================
package core_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIVU  = 3'b101;
  localparam logic [2:0] F3_REMU  = 3'b111;

  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_ITER = 2'd1;
  localparam logic [1:0] SEQ_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// alu_muldiv_seq : iterative unsigned MUL/MULHU/DIVU/REMU on the shared ALU
// Rev 1.0
// ============================================================================
module alu_muldiv_seq
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             alu_own_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_hi;
  logic             r_bad;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_alu_src1;
  logic [WIDTH-1:0] r_alu_src2;
  logic [3:0]       r_alu_ctrl;

  logic             w_supported;
  logic             w_iter;
  logic             w_carry;
  logic [WIDTH-1:0] w_div_r;
  logic             w_take;
  logic [WIDTH-1:0] w_src1;
  logic [WIDTH-1:0] w_src2;
  logic [3:0]       w_ctrl;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_final;

  always_comb begin
    case (funct3_i)
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: w_supported = 1'b1;
      default:                            w_supported = 1'b0;
    endcase
  end

  assign w_iter  = (r_state == SEQ_ITER);
  assign w_carry = (alu_result_i < r_acc);
  // Divide: restoring step on the (WIDTH+1)-bit shifted remainder {r_acc[MSB], w_div_r}.
  assign w_div_r = {r_acc[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_take  = r_acc[WIDTH-1] | (w_div_r >= r_opnd);

  always_comb begin
    if (r_is_div) begin
      w_src1    = w_div_r;
      w_src2    = r_opnd;
      w_ctrl    = ALU_SUB;
      w_acc_nxt = w_take ? alu_result_i : w_div_r;
      w_lo_nxt  = {r_lo[WIDTH-2:0], w_take};
    end else begin
      w_src1    = r_acc;
      w_src2    = r_lo[0] ? r_opnd : '0;
      w_ctrl    = ALU_ADD;
      w_acc_nxt = {w_carry, alu_result_i[WIDTH-1:1]};
      w_lo_nxt  = {alu_result_i[0], r_lo[WIDTH-1:1]};
    end
  end

  // Upper half / remainder lives in r_acc, low half / quotient in r_lo.
  assign w_final = r_bad ? '0 : (r_hi ? r_acc : r_lo);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= SEQ_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_hi       <= 1'b0;
      r_bad      <= 1'b0;
      r_acc      <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_result   <= '0;
      r_alu_src1 <= '0;
      r_alu_src2 <= '0;
      r_alu_ctrl <= ALU_ADD;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (start_i) begin
            r_is_div <= funct3_i[2];
            r_hi     <= funct3_i[1];
            r_bad    <= ~w_supported;
            r_acc    <= '0;
            r_lo     <= funct3_i[2] ? src1_i : src2_i;
            r_opnd   <= funct3_i[2] ? src2_i : src1_i;
            r_cnt    <= w_supported ? CNT_W'(WIDTH) : '0;
            r_state  <= w_supported ? SEQ_ITER : SEQ_DONE;
          end
        end
        SEQ_ITER: begin
          r_alu_src1 <= w_src1;
          r_alu_src2 <= w_src2;
          r_alu_ctrl <= w_ctrl;
          if (kill_i) begin
            r_state <= SEQ_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          r_state <= SEQ_IDLE;
          if (!kill_i) r_result <= w_final;
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign busy_o     = (r_state != SEQ_IDLE);
  assign done_o     = (r_state == SEQ_DONE) && !kill_i;
  assign result_o   = done_o ? w_final : r_result;
  assign alu_own_o  = w_iter;
  assign alu_src1_o = w_iter ? w_src1 : r_alu_src1;
  assign alu_src2_o = w_iter ? w_src2 : r_alu_src2;
  assign alu_ctrl_o = w_iter ? w_ctrl : r_alu_ctrl;

endmodule
`default_nettype wire
